// File: rtl/axis_pattern_check.sv
// AXIS sink that checks a counting data pattern and a fixed packet length.
// Define AXIS_PATTERN_CHECK_RAND_READY_EN to drive tready from a 16-bit LFSR.
module axis_pattern_check #(
    parameter int BUS_WIDTH = 2,
    parameter int PKT_LEN   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   clear,
    output logic [CNT_WIDTH-1:0]   pkt_count,
    output logic [CNT_WIDTH-1:0]   err_count,
    output logic                   data_err,
    output logic                   last_err,
    output logic                   in_pkt
);
    localparam int DW     = BUS_WIDTH * 8;
    localparam int IDX_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int CNT_W1 = CNT_WIDTH + 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BODY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
    logic [DW-1:0]        expected_q, expected_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                 data_err_q, data_err_d;
    logic                 last_err_q, last_err_d;
    logic                 tready_q, tready_d;
    logic                 beat, at_end, pkt_ok;
    logic [1:0]           err_inc;
    logic [CNT_WIDTH:0]   err_sum;

    assign beat   = s_axis_tvalid && tready_q;
    assign at_end = (beat_idx_q == LAST_IDX);

`ifdef AXIS_PATTERN_CHECK_RAND_READY_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Taps 16,14,13,11 in right-shift form; free-running and immune to clear.
    assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign tready_d = lfsr_d[0];

    always_ff @(posedge aclk) begin
        if (arst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end
`else
    assign tready_d = 1'b1;
`endif

    // Framing state machine: next state, beat index and framing verdict.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        last_err_d = 1'b0;
        pkt_ok     = 1'b0;
        if (beat) begin
            if (state_q == FLUSH) begin
                if (s_axis_tlast) begin
                    state_d    = IDLE;
                    beat_idx_d = '0;
                end
            end else if (s_axis_tlast) begin
                state_d    = IDLE;
                beat_idx_d = '0;
                pkt_ok     = at_end;
                last_err_d = !at_end;
            end else if (at_end) begin
                state_d    = FLUSH;
                beat_idx_d = '0;
                last_err_d = 1'b1;
            end else begin
                state_d    = BODY;
                beat_idx_d = beat_idx_q + 1'b1;
            end
        end
        if (clear) begin
            state_d    = IDLE;
            beat_idx_d = '0;
            last_err_d = 1'b0;
            pkt_ok     = 1'b0;
        end
    end

    // Data check with resync to received+1, and saturating counters.
    always_comb begin
        expected_d  = expected_q;
        data_err_d  = 1'b0;
        pkt_count_d = pkt_count_q;
        if (beat) begin
            data_err_d = (s_axis_tdata != expected_q);
            expected_d = s_axis_tdata + 1'b1;
        end
        if (pkt_ok && (pkt_count_q != CNT_MAX)) pkt_count_d = pkt_count_q + 1'b1;
        err_inc     = {1'b0, data_err_d} + {1'b0, last_err_d};
        err_sum     = {1'b0, err_count_q} + CNT_W1'(err_inc);
        err_count_d = err_sum[CNT_WIDTH] ? CNT_MAX : err_sum[CNT_WIDTH-1:0];
        if (clear) begin
            expected_d  = '0;
            data_err_d  = 1'b0;
            pkt_count_d = '0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample together.
        if (arst) begin
            state_q     <= IDLE;
            beat_idx_q  <= '0;
            expected_q  <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            data_err_q  <= 1'b0;
            last_err_q  <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_idx_q  <= beat_idx_d;
            expected_q  <= expected_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            data_err_q  <= data_err_d;
            last_err_q  <= last_err_d;
            tready_q    <= tready_d;
        end
    end

    always_comb begin
        s_axis_tready = tready_q;
        pkt_count     = pkt_count_q;
        err_count     = err_count_q;
        data_err      = data_err_q;
        last_err      = last_err_q;
        in_pkt        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_axis_pattern_check.sv
// Scoreboard bench for axis_pattern_check: a driver pushes expected results, a monitor pops them.
// A second instance with CNT_WIDTH=2 shares the stimulus to exercise counter saturation.
module tb_axis_pattern_check;
    localparam int PKT_LEN = 16;

    typedef struct {
        bit derr;
        bit lerr;
        int pkt;
        int err;
        bit inp;
    } exp_t;

    logic        aclk = 1'b0;
    logic        arst;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        clear;
    logic [15:0] pkt_count, err_count;
    logic        data_err, last_err, in_pkt;
    logic        tready2, data_err2, last_err2, in_pkt2;
    logic [1:0]  pkt_count2, err_count2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [15:0] m_exp;
    int          m_state, m_idx, m_pkt, m_err;

    always #5 aclk = ~aclk;

    axis_pattern_check #(.BUS_WIDTH(2), .PKT_LEN(PKT_LEN), .CNT_WIDTH(16)) dut (
        .aclk(aclk), .arst(arst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .clear(clear), .pkt_count(pkt_count), .err_count(err_count),
        .data_err(data_err), .last_err(last_err), .in_pkt(in_pkt)
    );

    axis_pattern_check #(.BUS_WIDTH(2), .PKT_LEN(PKT_LEN), .CNT_WIDTH(2)) dut_sat (
        .aclk(aclk), .arst(arst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready2),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .clear(clear), .pkt_count(pkt_count2), .err_count(err_count2),
        .data_err(data_err2), .last_err(last_err2), .in_pkt(in_pkt2)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        m_exp   = 16'd0;
        m_state = 0;
        m_idx   = 0;
        m_pkt   = 0;
        m_err   = 0;
    endtask

    // Reference behaviour for one accepted beat (or a clear cycle); state 0/1/2 = IDLE/BODY/FLUSH.
    task automatic model_beat(input logic [15:0] d, input logic l, input logic clr);
        exp_t e;
        e.derr = 1'b0;
        e.lerr = 1'b0;
        if (clr) begin
            model_reset();
        end else begin
            e.derr = (d != m_exp);
            m_exp  = d + 16'd1;
            if (m_state == 2) begin
                if (l) begin m_state = 0; m_idx = 0; end
            end else if (l) begin
                if (m_idx == PKT_LEN - 1) m_pkt = sat(m_pkt + 1, 65535);
                else                      e.lerr = 1'b1;
                m_state = 0;
                m_idx   = 0;
            end else if (m_idx == PKT_LEN - 1) begin
                e.lerr  = 1'b1;
                m_state = 2;
                m_idx   = 0;
            end else begin
                m_state = 1;
                m_idx++;
            end
            m_err = sat(m_err + int'(e.derr) + int'(e.lerr), 65535);
        end
        e.pkt = m_pkt;
        e.err = m_err;
        e.inp = (m_state != 0);
        sb.push_back(e);
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l);
        bit done = 1'b0;
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int n = 0; n < 200 && !done; n++) begin
            if (s_axis_tready) begin
                model_beat(d, l, 1'b0);
                done = 1'b1;
                @(posedge aclk);
            end else begin
                @(negedge aclk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got tready=0 expected 1 within 200 cycles");
        end
    endtask

    // n beats of data start, start+1, ...; tlast on beat last_pos (or never if negative).
    task automatic send_seq(input logic [15:0] start, input int n, input int last_pos);
        for (int i = 0; i < n; i++) send_beat(start + 16'(i), (i == last_pos));
    endtask

    task automatic idle(input int n);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) @(negedge aclk);
    endtask

    task automatic do_clear(input logic with_beat, input logic [15:0] d);
        @(negedge aclk);
        clear         = 1'b1;
        s_axis_tvalid = with_beat;
        s_axis_tdata  = d;
        s_axis_tlast  = 1'b0;
        model_beat(d, 1'b0, 1'b1);
        @(negedge aclk);
        clear         = 1'b0;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int pkt, input int err);
        check({tag, "_pkt"}, 32'(pkt_count), 32'(pkt));
        check({tag, "_err"}, 32'(err_count), 32'(err));
        check({tag, "_err_sat"}, 32'(err_count2), 32'(sat(err, 3)));
    endtask

`ifdef AXIS_PATTERN_CHECK_RAND_READY_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction
`endif

    // Monitor: samples the handshake at the edge, compares outputs 1 time unit later.
    initial begin : monitor
        logic ev, rst_s;
        exp_t e;
`ifdef AXIS_PATTERN_CHECK_RAND_READY_EN
        logic [15:0] tb_lfsr = 16'hACE1;
`endif
        forever begin
            @(posedge aclk);
            rst_s = arst;
            ev    = !arst && (clear || (s_axis_tvalid && s_axis_tready));
            #1;
`ifdef AXIS_PATTERN_CHECK_RAND_READY_EN
            if (rst_s) tb_lfsr = 16'hACE1;
            else       tb_lfsr = lfsr_step(tb_lfsr);
            check("tready", 32'(s_axis_tready), rst_s ? 32'd0 : 32'(tb_lfsr[0]));
`else
            check("tready", 32'(s_axis_tready), rst_s ? 32'd0 : 32'd1);
`endif
            if (ev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got output event expected none at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("data_err", 32'(data_err), 32'(e.derr));
                    check("last_err", 32'(last_err), 32'(e.lerr));
                    check("pkt_count", 32'(pkt_count), 32'(e.pkt));
                    check("err_count", 32'(err_count), 32'(e.err));
                    check("in_pkt", 32'(in_pkt), 32'(e.inp));
                    check("pkt_count_sat", 32'(pkt_count2), 32'(sat(e.pkt, 3)));
                    check("err_count_sat", 32'(err_count2), 32'(sat(e.err, 3)));
                end
            end else if (!rst_s) begin
                check("flags_quiet", 32'({data_err, last_err}), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst          = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        clear         = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_flags", 32'({data_err, last_err, in_pkt}), 32'd0);
        check_counts("rst", 0, 0);
        arst = 1'b0;

        // Four clean packets, data 0..63.
        for (int p = 0; p < 4; p++) send_seq(16'(p * 16), 16, 15);
        idle(2);
        check_counts("clean4", 4, 0);

        // Single discontinuity at beat 5 (jump to 0x00FF), then the pattern continues.
        do_clear(1'b0, 16'h0);
        send_seq(16'h0000, 5, -1);
        send_seq(16'h00FF, 11, 10);
        idle(2);
        check_counts("data_jump", 1, 1);

        // Short 8-beat packet then a correct 16-beat packet.
        do_clear(1'b0, 16'h0);
        send_seq(16'h0000, 8, 7);
        send_seq(16'h0008, 16, 15);
        idle(2);
        check_counts("short_pkt", 1, 1);

        // 20-beat packet: last_err at beat 15, FLUSH until beat 19, then a good packet.
        do_clear(1'b0, 16'h0);
        send_seq(16'h0000, 20, 19);
        idle(1);
        check_counts("long_pkt", 0, 1);
        send_seq(16'h0014, 16, 15);
        idle(2);
        check_counts("after_long", 1, 1);

        // Data and framing error on the same beat: err_count +2.
        do_clear(1'b0, 16'h0);
        send_seq(16'h0000, 15, -1);
        send_beat(16'h0200, 1'b0);
        send_beat(16'h0201, 1'b1);
        idle(2);
        check_counts("dual_err", 0, 2);

        // Five bad-data beats: 16-bit counter reaches 7, 2-bit counter holds at 3.
        for (int i = 0; i < 5; i++) send_beat(16'h1000, 1'b0);
        idle(2);
        check_counts("saturate", 0, 7);

        // Clear with a same-cycle handshake: beat discarded, pattern restarts at 0.
        do_clear(1'b1, 16'h5555);
        check_counts("clear", 0, 0);
        check("clear_in_pkt", 32'(in_pkt), 32'd0);
        send_beat(16'h0000, 1'b0);
        idle(1);
        check_counts("post_clear", 0, 0);

        // Pattern wrap 0xFFFF -> 0x0000 after one resync error.
        do_clear(1'b0, 16'h0);
        send_seq(16'hFFFD, 5, -1);
        idle(2);
        check_counts("wrap", 0, 1);

        // Reset mid-packet with tvalid held high.
        send_seq(16'h0002, 3, -1);
        @(negedge aclk);
        arst          = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'h0005;
        repeat (2) @(negedge aclk);
        check("mid_rst_tready", 32'(s_axis_tready), 32'd0);
        check("mid_rst_flags", 32'({data_err, last_err, in_pkt}), 32'd0);
        check_counts("mid_rst", 0, 0);
        model_reset();
        arst          = 1'b0;
        s_axis_tvalid = 1'b0;

        send_seq(16'h0000, 16, 15);
        idle(3);
        check_counts("post_rst", 1, 0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
